idu_stage: RTL and testbench

IDU_STAGE -- requirements
Module: idu_stage

---
 rtl/npc_pkg.sv | 47 ++++
 rtl/Reg.sv | 21 ++
 rtl/imm_gen.sv | 24 ++
 rtl/idu_stage.sv | 133 +++++++++++++
 tb/tb_idu_stage.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/npc_pkg.sv
// Shared decode types and constants for the NPC pipeline.
// Instruction format classes, base opcodes and special encodings.
package npc_pkg;

    typedef enum logic [2:0] {
        TYPE_R   = 3'd0,
        TYPE_I   = 3'd1,
        TYPE_S   = 3'd2,
        TYPE_B   = 3'd3,
        TYPE_U   = 3'd4,
        TYPE_J   = 3'd5,
        TYPE_BAD = 3'd7
    } inst_type_t;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    function automatic inst_type_t classify(input logic [6:0] op);
        inst_type_t t;
        case (op)
            OP_OP:     t = TYPE_R;
            OP_IMM,
            OP_LOAD,
            OP_JALR,
            OP_SYSTEM: t = TYPE_I;
            OP_STORE:  t = TYPE_S;
            OP_BRANCH: t = TYPE_B;
            OP_LUI,
            OP_AUIPC:  t = TYPE_U;
            OP_JAL:    t = TYPE_J;
            default:   t = TYPE_BAD;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/Reg.sv
// Generic register with synchronous active-high reset and write enable.
module Reg #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/imm_gen.sv
// Immediate generator: sign-extended immediate for each RISC-V format.
module imm_gen
    import npc_pkg::*;
(
    input  logic [31:0] inst,
    input  inst_type_t  inst_type,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'h0;
        case (inst_type)
            TYPE_I: imm = {{20{inst[31]}}, inst[31:20]};
            TYPE_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            TYPE_B: imm = {{19{inst[31]}}, inst[31], inst[7],
                           inst[30:25], inst[11:8], 1'b0};
            TYPE_U: imm = {inst[31:12], 12'h0};
            TYPE_J: imm = {{11{inst[31]}}, inst[31], inst[19:12],
                           inst[20], inst[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/idu_stage.sv
// Decode stage: one-entry skid buffer between IFU and EXU with
// combinational decode of the buffered instruction.
module idu_stage
    import npc_pkg::*;
#(
    parameter int RVE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in_ifu,
    output logic        ready_out_ifu,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    input  logic        flush,
    input  logic        ready_in_exu,
    output logic        valid_out_exu,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic [2:0]  inst_type,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic        illegal,
    output logic        ebreak
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        w_ready;
    logic        w_cap;
    inst_type_t  w_type;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_use_rd;
    logic        w_bad_reg;

    assign w_ready = ((r_state == S_EMPTY) || ready_in_exu) && !flush;
    assign w_cap   = valid_in_ifu && w_ready;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else if (w_cap) begin
            w_state_nxt = S_FULL;
        end else if (r_state == S_FULL && ready_in_exu) begin
            w_state_nxt = S_EMPTY;
        end
    end

    Reg #(.WIDTH(1), .RESET_VAL(S_EMPTY)) u_state (
        .clk (clk),
        .rst (rst),
        .din (w_state_nxt),
        .dout(r_state),
        .wen (1'b1)
    );

    Reg #(.WIDTH(32), .RESET_VAL(32'h0)) u_pc (
        .clk (clk),
        .rst (rst),
        .din (pc_in),
        .dout(r_pc),
        .wen (w_cap)
    );

    Reg #(.WIDTH(32), .RESET_VAL(NOP)) u_inst (
        .clk (clk),
        .rst (rst),
        .din (inst_in),
        .dout(r_inst),
        .wen (w_cap)
    );

    assign w_type = classify(r_inst[6:0]);

    // Register fields actually read/written by each format (RV32E check)
    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        case (w_type)
            TYPE_R: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_rd  = 1'b1;
            end
            TYPE_I: begin
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
            end
            TYPE_S, TYPE_B: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            TYPE_U, TYPE_J: w_use_rd = 1'b1;
            default: ;
        endcase
    end

    assign w_bad_reg = (w_use_rs1 && r_inst[19])
                    || (w_use_rs2 && r_inst[24])
                    || (w_use_rd  && r_inst[11]);

    imm_gen u_imm_gen (
        .inst     (r_inst),
        .inst_type(w_type),
        .imm      (imm)
    );

    assign ready_out_ifu = w_ready;
    assign valid_out_exu = (r_state == S_FULL);
    assign pc_out        = r_pc;
    assign inst_out      = r_inst;
    assign rs1           = r_inst[19:15];
    assign rs2           = r_inst[24:20];
    assign rd            = r_inst[11:7];
    assign inst_type     = w_type;
    assign funct3        = r_inst[14:12];
    assign funct7b5      = r_inst[30];
    assign illegal       = (w_type == TYPE_BAD)
                        || ((RVE != 0) && w_bad_reg);
    assign ebreak        = (r_inst == EBREAK);

endmodule

// File: tb/tb_idu_stage.sv
// Self-checking bench for idu_stage: directed table, hand sequences
// and random traffic against a transaction-level reference model.
module tb_idu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in_ifu;
    logic [31:0] pc_in;
    logic [31:0] inst_in;
    logic        flush;
    logic        ready_in_exu;

    logic        ready_out_ifu, valid_out_exu;
    logic [31:0] pc_out, inst_out, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  inst_type, funct3;
    logic        funct7b5, illegal, ebreak;

    logic        e_ready, e_valid;
    logic [31:0] e_pc, e_inst, e_imm;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [2:0]  e_type, e_f3;
    logic        e_f7b5, e_illegal, e_ebreak;

    always #5 clk = ~clk;

    idu_stage #(.RVE(0)) dut (
        .clk(clk), .rst(rst),
        .valid_in_ifu(valid_in_ifu), .ready_out_ifu(ready_out_ifu),
        .pc_in(pc_in), .inst_in(inst_in), .flush(flush),
        .ready_in_exu(ready_in_exu), .valid_out_exu(valid_out_exu),
        .pc_out(pc_out), .inst_out(inst_out),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .inst_type(inst_type), .funct3(funct3), .funct7b5(funct7b5),
        .illegal(illegal), .ebreak(ebreak)
    );

    idu_stage #(.RVE(1)) dut_e (
        .clk(clk), .rst(rst),
        .valid_in_ifu(valid_in_ifu), .ready_out_ifu(e_ready),
        .pc_in(pc_in), .inst_in(inst_in), .flush(flush),
        .ready_in_exu(ready_in_exu), .valid_out_exu(e_valid),
        .pc_out(e_pc), .inst_out(e_inst),
        .rs1(e_rs1), .rs2(e_rs2), .rd(e_rd), .imm(e_imm),
        .inst_type(e_type), .funct3(e_f3), .funct7b5(e_f7b5),
        .illegal(e_illegal), .ebreak(e_ebreak)
    );

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic [2:0]  f3;
        logic        f7b5;
        logic        ill;
        logic        ebk;
    } dec_t;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  typ;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic        ill, ill_e, ebk;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    bit          m_full;
    logic [31:0] m_pc;
    logic [31:0] m_inst;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    function automatic int sx(input int v, input int bits);
        int r;
        r = v & ((1 << bits) - 1);
        if (r >= (1 << (bits - 1))) r = r - (1 << bits);
        return r;
    endfunction

    // Reference decode straight from the ISA encoding tables
    function automatic dec_t ref_dec(input logic [31:0] i, input bit rve);
        dec_t d;
        bit u1, u2, ud;
        int v;
        d = '0;
        u1 = 0; u2 = 0; ud = 0; v = 0;
        d.rs1 = i[19:15];
        d.rs2 = i[24:20];
        d.rd = i[11:7];
        d.f3 = i[14:12];
        d.f7b5 = i[30];
        case (i[6:0])
            7'h33: begin d.typ = 3'd0; u1 = 1; u2 = 1; ud = 1; end
            7'h13, 7'h03, 7'h67, 7'h73: begin
                d.typ = 3'd1; u1 = 1; ud = 1;
                v = sx(int'(i[31:20]), 12);
            end
            7'h23: begin
                d.typ = 3'd2; u1 = 1; u2 = 1;
                v = sx(int'(i[31:25]) * 32 + int'(i[11:7]), 12);
            end
            7'h63: begin
                d.typ = 3'd3; u1 = 1; u2 = 1;
                v = sx(int'(i[31]) * 4096 + int'(i[7]) * 2048
                       + int'(i[30:25]) * 32 + int'(i[11:8]) * 2, 13);
            end
            7'h37, 7'h17: begin
                d.typ = 3'd4; ud = 1;
                v = int'(i & 32'hFFFF_F000);
            end
            7'h6F: begin
                d.typ = 3'd5; ud = 1;
                v = sx(int'(i[31]) * (1 << 20) + int'(i[19:12]) * 4096
                       + int'(i[20]) * 2048 + int'(i[30:21]) * 2, 21);
            end
            default: begin d.typ = 3'd7; d.ill = 1; end
        endcase
        d.imm = 32'(v);
        if (rve && ((u1 && d.rs1 >= 16) || (u2 && d.rs2 >= 16)
                    || (ud && d.rd >= 16)))
            d.ill = 1;
        d.ebk = (i == 32'h0010_0073);
        return d;
    endfunction

    function automatic dec_t dut_dec();
        return {rs1, rs2, rd, imm, inst_type, funct3, funct7b5,
                illegal, ebreak};
    endfunction

    // One clock: drive, check at negedge against the model, advance model
    task automatic cycle(input logic v, input logic [31:0] p,
                         input logic [31:0] in, input logic fl,
                         input logic rdy, input logic r, input int tk);
        dec_t ex, exe;
        bit cap;
        valid_in_ifu = v; pc_in = p; inst_in = in;
        flush = fl; ready_in_exu = rdy; rst = r;
        @(negedge clk);
        ex = ref_dec(m_inst, 0);
        exe = ref_dec(m_inst, 1);
        chk("valid", 64'(valid_out_exu), 64'(m_full));
        chk("ready", 64'(ready_out_ifu), 64'((!m_full || rdy) && !fl));
        chk("pc_out", 64'(pc_out), 64'(m_pc));
        chk("inst_out", 64'(inst_out), 64'(m_inst));
        chk("decode", 64'(dut_dec()), 64'(ex));
        chk("illegal_rve", 64'(e_illegal), 64'(exe.ill));
        if (tk >= 0) begin
            chk("tbl_valid", 64'(valid_out_exu), 64'(1));
            chk("tbl_type", 64'(inst_type), 64'(tbl[tk].typ));
            chk("tbl_regs", 64'({rs1, rs2, rd}),
                64'({tbl[tk].rs1, tbl[tk].rs2, tbl[tk].rd}));
            chk("tbl_f3", 64'(funct3), 64'(tbl[tk].f3));
            chk("tbl_imm", 64'(imm), 64'(tbl[tk].imm));
            chk("tbl_ill", 64'({illegal, e_illegal, ebreak}),
                64'({tbl[tk].ill, tbl[tk].ill_e, tbl[tk].ebk}));
        end
        @(posedge clk);
        if (r) begin
            m_full = 0; m_pc = 32'h0; m_inst = 32'h13;
        end else if (fl) begin
            m_full = 0;
        end else begin
            cap = v && (!m_full || rdy);
            if (cap) begin
                m_full = 1; m_pc = p; m_inst = in;
            end else if (m_full && rdy) begin
                m_full = 0;
            end
        end
        #1;
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [6:0] ops[10];
        logic [31:0] x;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73,
                7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        x = $urandom;
        if ($urandom_range(0, 3) != 0)
            x[6:0] = ops[$urandom_range(0, 9)];
        return x;
    endfunction

    initial begin
        logic [31:0] a_inst;
        tbl[0] = '{32'h0050_0093, 3'd1, 5'd0, 5'd5, 5'd1, 3'd0,
                   32'h0000_0005, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{32'hFE20_AE23, 3'd2, 5'd1, 5'd2, 5'd28, 3'd2,
                   32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{32'hFF9F_F06F, 3'd5, 5'd31, 5'd25, 5'd0, 3'd7,
                   32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{32'h0010_0073, 3'd1, 5'd0, 5'd1, 5'd0, 3'd0,
                   32'h0000_0001, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{32'hFFFF_FFFF, 3'd7, 5'd31, 5'd31, 5'd31, 3'd7,
                   32'h0000_0000, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{32'h0100_0833, 3'd0, 5'd0, 5'd16, 5'd16, 3'd0,
                   32'h0000_0000, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{32'h1234_50B7, 3'd4, 5'd8, 5'd3, 5'd1, 3'd5,
                   32'h1234_5000, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{32'hFE00_0EE3, 3'd3, 5'd0, 5'd0, 5'd29, 3'd0,
                   32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0};

        valid_in_ifu = 0; pc_in = 0; inst_in = 0;
        flush = 0; ready_in_exu = 0; rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        m_full = 0; m_pc = 32'h0; m_inst = 32'h13;

        chk("rst_ready", 64'(ready_out_ifu), 64'(1));
        chk("rst_valid", 64'(valid_out_exu), 64'(0));
        chk("rst_pc_inst", 64'({pc_out, inst_out}), 64'h0000_0000_0000_0013);
        chk("rst_regs_imm", 64'({rs1, rs2, rd, imm}), 64'(0));
        chk("rst_type_flags", 64'({inst_type, illegal, ebreak}),
            64'({3'd1, 1'b0, 1'b0}));

        // Back-to-back table stream; each entry checked one cycle later
        for (int k = 0; k < 8; k++)
            cycle(1, 32'h8000_0000 + 32'(4 * k), tbl[k].inst, 0, 1, 0, k - 1);
        cycle(0, 0, 0, 0, 1, 0, 7);

        // Stall: FULL with EXU not ready while inst_in keeps changing
        a_inst = 32'h00A0_0113;
        cycle(1, 32'h8000_0100, a_inst, 0, 0, 0, -1);
        for (int s = 0; s < 3; s++) begin
            cycle(1, $urandom, $urandom, 0, 0, 0, -1);
            chk("stall_ready", 64'(ready_out_ifu), 64'(0));
            chk("stall_hold", 64'({pc_out, inst_out}),
                {32'h8000_0100, a_inst});
        end
        cycle(1, 32'h8000_0104, 32'h0030_8193, 0, 1, 0, -1);
        chk("release_cap", 64'({valid_out_exu, inst_out}),
            64'({1'b1, 32'h0030_8193}));

        // Flush while FULL with an offer pending
        cycle(1, 32'h8000_0200, 32'h0000_0293, 1, 0, 0, -1);
        chk("flush_valid", 64'(valid_out_exu), 64'(0));
        chk("flush_keep", 64'(inst_out), 64'h0030_8193);
        cycle(0, 0, 0, 0, 0, 0, -1);

        // Reset mid-FULL
        cycle(1, 32'h8000_0300, 32'h0040_0313, 0, 0, 0, -1);
        cycle(1, 32'h8000_0304, 32'h0050_0393, 0, 0, 1, -1);
        chk("midrst_valid", 64'(valid_out_exu), 64'(0));
        chk("midrst_buf", 64'({pc_out, inst_out}), 64'h0000_0000_0000_0013);
        chk("midrst_dec", 64'({rs1, rs2, rd, imm, inst_type, illegal, ebreak}),
            64'({5'd0, 5'd0, 5'd0, 32'd0, 3'd1, 1'b0, 1'b0}));
        chk("midrst_ready", 64'(ready_out_ifu), 64'(1));

        for (int n = 0; n < 400; n++)
            cycle($urandom_range(0, 3) != 0, $urandom, rnd_inst(),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 49) == 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
